mux4_arbiter: RTL and testbench
===============================

MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per owner; legal range 2..16.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 req  input  4  request vector; bit i = requester i wants the shared 4:1 mux.
REQ-005 grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 sel  output  2  registered mux select, drives the 2-bit select of the shared 4:1 mux; equals the owner index while busy.
REQ-007 busy  output  1  registered; 1 while any grant bit is set.

Function
REQ-008 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-009 Round-robin pointer ptr (2 bits) SHALL name the highest-priority requester; priority descends ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-010 In IDLE with req != 0, the winner SHALL be the first set bit at or after ptr; grant/sel/busy reflect it on the next rising edge (1-cycle latency); hold_cnt clears to 0.
REQ-011 In IDLE with req == 0, outputs SHALL hold grant=0, busy=0, sel unchanged.
REQ-012 In GRANT, hold_cnt SHALL increment by 1 each cycle the owner keeps its grant.
REQ-013 Release SHALL occur at the edge after req[owner]==0 is sampled, or at the edge after the cycle where hold_cnt == MAX_HOLD-1 (owner holds at most MAX_HOLD cycles).
REQ-014 On release ptr SHALL become owner+1 mod 4 (wrap 3->0).
REQ-015 On release, if any req bit (after pointer update) is set, the new winner SHALL be granted at that same edge with no idle gap, and hold_cnt SHALL clear; otherwise state returns to IDLE with grant=0, busy=0.
REQ-016 An owner whose grant times out while still requesting SHALL be re-granted only if no other requester is active (it is lowest priority after the ptr update).
REQ-017 Requests from non-owners during GRANT SHALL not pre-empt the owner.
REQ-018 grant SHALL never contain more than one set bit; busy SHALL equal |grant every cycle.
REQ-019 Owner dropping req and another raising req in the same cycle SHALL be treated as release followed by immediate arbitration per REQ-015.

Reset
REQ-020 resetn low SHALL immediately and asynchronously force state=IDLE, grant=0, sel=0, busy=0, ptr=0, hold_cnt=0, regardless of clock.
REQ-021 Reset asserted mid-grant SHALL abort the grant; first arbitration after deassertion SHALL use ptr=0.
REQ-022 Outputs SHALL be stable (no arbitration) during the first edge on which resetn is low.

Structure
REQ-023 State encodings (IDLE=0, GRANT=1) and the hold-counter width (4 bits) SHALL live in the shared header mux_ctrl_defs.vh.
REQ-024 The circular priority search SHALL be a combinational sub-module rr_pick (inputs req[3:0], ptr[1:0]; outputs idx[1:0], any); all registers stay in mux4_arbiter.
REQ-025 The block SHALL not contain the data mux; sel connects externally to the existing 4:1 mux.

Verification
REQ-026 Reset then req=4'b0100 held -> after 1 edge grant=0100, sel=2, busy=1; after 4 edges of hold (MAX_HOLD=4) with no other requesters, re-granted to 2 with hold_cnt restarted.
REQ-027 req=4'b1111 continuous from reset -> grants rotate 0,1,2,3,0 each lasting exactly 4 cycles, no gap cycles.
REQ-028 Owner 1 granted, req drops to 4'b1000 -> next edge grant=1000, sel=3, ptr=2; then req=0 -> IDLE, busy=0, sel stays 3.
REQ-029 Owner 3 times out with req=4'b1001 -> ptr wraps to 0, grant=0001.
REQ-030 resetn pulsed low mid-grant (owner 2) -> grant=0, sel=0, busy=0 asynchronously; with req=4'b0110 after release, first grant=0010.
REQ-031 Random req stream, 10k cycles -> grant always one-hot or zero, busy==|grant, no owner exceeds 4 consecutive cycles while another requester waits.

Source files
------------

// File: rtl/mux4_arbiter_pkg.sv
// mux4_arbiter_pkg
//   Shared definitions for the 4-way round-robin mux arbiter:
//   FSM state encodings, hold-counter width and a one-hot helper.
package mux4_arbiter_pkg;

    // FSM encodings (legacy-compatible plain constants)
    localparam logic [0:0] ST_IDLE  = 1'b0;  // no owner
    localparam logic [0:0] ST_GRANT = 1'b1;  // exactly one owner

    // Hold counter width; covers MAX_HOLD-1 for MAX_HOLD up to 16
    localparam int HOLD_W = 4;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_arbiter_if.sv
// mux4_arbiter_if
//   Request/grant bundle between the requesters and the arbiter.
//   req   : 4-bit request vector, bit i = requester i wants the mux
//   grant : registered one-hot grant (zero when no owner)
//   sel   : registered 2-bit select for the external 4:1 mux
//   busy  : registered, equals |grant
//
// Handshake: req[i] is a level that the requester holds for as long as it
// wants the mux; grant[i] is the ready/ownership response and appears one
// edge after arbitration. Ownership ends at the edge after req[i] is seen
// low, or after MAX_HOLD consecutive grant cycles. There is no separate
// valid/ready pair: req acts as valid, grant acts as ready.
interface mux4_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    modport master (output req, input grant, input sel, input busy);
    modport slave  (input req, output grant, output sel, output busy);
endinterface

// File: rtl/mux4_arbiter_rr_pick.sv
// rr_pick
//   Combinational circular priority search. Priority descends
//   ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   req : request vector        ptr : highest-priority index
//   idx : winning index         any : at least one request present
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        idx  = ptr;
        cand = ptr;
        any  = |req;
        // Scan from the lowest priority back to ptr so the last hit,
        // i.e. the highest-priority set bit, is what remains in idx.
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// mux4_arbiter
//   Round-robin arbiter for a shared 4:1 mux (the mux itself is external).
//   Ports:
//     clock        rising-edge clock
//     resetn       asynchronous active-low reset
//     bus          slave side of mux4_arbiter_if (req in; grant/sel/busy out)
//     dbg_state_o  FSM state (ST_IDLE / ST_GRANT)
//     dbg_ptr_o    round-robin pointer
//     dbg_hold_o   hold counter of the current owner
//   Parameter MAX_HOLD (2..16): maximum consecutive grant cycles per owner.
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clock,
    input  logic              resetn,
    mux4_arbiter_if.slave     bus,
    output logic [0:0]        dbg_state_o,
    output logic [1:0]        dbg_ptr_o,
    output logic [HOLD_W-1:0] dbg_hold_o
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q,   sel_d;
    logic              busy_q,  busy_d;

    logic [1:0] ptr_next;
    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       release_now;

    // Pointer value after releasing the current owner (wraps 3 -> 0)
    assign ptr_next = sel_q + 2'd1;

    // While busy the arbiter only matters on release, and then it must use
    // the already-advanced pointer so the old owner becomes lowest priority.
    assign pick_ptr = (state_q == ST_GRANT) ? ptr_next : ptr_q;

    assign release_now = (state_q == ST_GRANT) &&
                         (!bus.req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)));

    rr_pick u_rr_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    grant_d = idx_to_onehot(pick_idx);
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d  = ptr_next;
                    hold_d = '0;
                    if (pick_any) begin
                        // Hand over at the same edge, no idle gap
                        sel_d   = pick_idx;
                        grant_d = idx_to_onehot(pick_idx);
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_hold_o  = hold_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
module tb_mux4_arbiter;
    import mux4_arbiter_pkg::*;

    localparam int MAX_HOLD = 4;

    logic              clock;
    logic              resetn;
    logic [0:0]        dbg_state;
    logic [1:0]        dbg_ptr;
    logic [HOLD_W-1:0] dbg_hold;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who owns the mux, how many cycles it has owned it,
    // the priority pointer and the last select value.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_sel;

    mux4_arbiter_if bus ();

    mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr),
        .dbg_hold_o  (dbg_hold)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model ----------------
    function automatic int first_req(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner < 0) begin
            w = first_req(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_sel   = w;
            end
        end else if (!r[m_owner] || m_held == MAX_HOLD) begin
            m_ptr   = (m_owner + 1) % 4;
            w       = first_req(r, m_ptr);
            m_owner = w;
            if (w >= 0) begin
                m_sel  = w;
                m_held = 1;
            end
        end else begin
            m_held++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        resetn  = 1'b0;
        bus.req = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    // Drive req for one cycle, advance the model at the edge, sample #1 later
    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clock);
        model_step(r);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn  = 1'b0;
        bus.req = 4'b1111;
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0 ||
            dbg_ptr !== 2'd0 || dbg_state !== ST_IDLE || dbg_hold !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: grant=%b sel=%0d busy=%b ptr=%0d state=%0d hold=%0d, expected 0000/0/0/0/0/0",
                     bus.grant, bus.sel, bus.busy, dbg_ptr, dbg_state, dbg_hold);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_arb: grant=%b busy=%b, expected 0000/0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            step(4'b0100);
            tests_run++;
            if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.busy !== 1'b1 ||
                dbg_hold !== HOLD_W'((c - 1) % MAX_HOLD)) begin
                tests_failed++;
                $display("FAIL hold_timeout c=%0d: grant=%b sel=%0d busy=%b hold=%0d, expected 0100/2/1/%0d",
                         c, bus.grant, bus.sel, bus.busy, dbg_hold, (c - 1) % MAX_HOLD);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] g;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step(4'b1111);
            g = '0;
            g[((c - 1) / MAX_HOLD) % 4] = 1'b1;
            tests_run++;
            if (bus.grant !== g || bus.grant !== exp_grant() || bus.busy !== 1'b1 ||
                bus.sel !== 2'(((c - 1) / MAX_HOLD) % 4)) begin
                tests_failed++;
                $display("FAIL rotate c=%0d: grant=%b sel=%0d busy=%b, expected grant=%b busy=1",
                         c, bus.grant, bus.sel, bus.busy, g);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        step(4'b0010);
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
            tests_failed++;
            $display("FAIL drop_owner1: grant=%b sel=%0d, expected 0010/1", bus.grant, bus.sel);
        end
        step(4'b1000);
        tests_run++;
        if (bus.grant !== 4'b1000 || bus.sel !== 2'd3 || dbg_ptr !== 2'd2 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_handover: grant=%b sel=%0d ptr=%0d busy=%b, expected 1000/3/2/1",
                     bus.grant, bus.sel, dbg_ptr, bus.busy);
        end
        step(4'b0000);
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.sel !== 2'd3 || bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL drop_idle: grant=%b sel=%0d busy=%b state=%0d, expected 0000/3/0/0",
                     bus.grant, bus.sel, bus.busy, dbg_state);
        end
        step(4'b0000);
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.sel !== 2'd3 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: grant=%b sel=%0d busy=%b, expected 0000/3/0",
                     bus.grant, bus.sel, bus.busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(4'b1000);
        for (int c = 0; c < MAX_HOLD - 1; c++) step(4'b1001);
        tests_run++;
        if (bus.grant !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_before: grant=%b, expected 1000", bus.grant);
        end
        step(4'b1001);
        tests_run++;
        if (bus.grant !== 4'b0001 || bus.sel !== 2'd0 || dbg_ptr !== 2'd0 || dbg_hold !== '0) begin
            tests_failed++;
            $display("FAIL wrap_after: grant=%b sel=%0d ptr=%0d hold=%0d, expected 0001/0/0/0",
                     bus.grant, bus.sel, dbg_ptr, dbg_hold);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b0001);
        step(4'b0000);   // ptr moves to 1 so the later check proves it resets
        step(4'b0100);
        tests_run++;
        if (bus.grant !== 4'b0100 || bus.sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL areset_setup: grant=%b sel=%0d, expected 0100/2", bus.grant, bus.sel);
        end
        bus.req = 4'b0110;
        #1;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0 || dbg_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL areset_async: grant=%b sel=%0d busy=%b ptr=%0d, expected 0000/0/0/0",
                     bus.grant, bus.sel, bus.busy, dbg_ptr);
        end
        #1;
        resetn = 1'b1;
        model_reset();
        step(4'b0110);
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.sel !== 2'd1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_first_grant: grant=%b sel=%0d busy=%b, expected 0010/1/1",
                     bus.grant, bus.sel, bus.busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        int         bad = 0;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            // Mostly keep the previous pattern so owners reach their hold limit
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
            tests_run++;
            if (bus.grant !== exp_grant() || bus.sel !== 2'(m_sel) || bus.busy !== (m_owner >= 0) ||
                (m_owner >= 0 && dbg_hold !== HOLD_W'(m_held - 1)) ||
                !$onehot0(bus.grant) || bus.busy !== (|bus.grant)) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random c=%0d req=%b: grant=%b sel=%0d busy=%b hold=%0d, expected grant=%b sel=%0d busy=%0d hold=%0d",
                             c, r, bus.grant, bus.sel, bus.busy, dbg_hold, exp_grant(), m_sel,
                             (m_owner >= 0), m_held - 1);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        resetn  = 1'b0;
        bus.req = 4'b0000;
        model_reset();
        test_reset();
        test_hold_timeout();
        test_rotate();
        test_drop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
